// File: rtl/vx_lsu_csr_bridge_if.sv
// Bundle of LSU request/response and CSR access-port signals around the LSU-to-CSR bridge.
// slave is the bridge's view; master is the view of whatever drives the LSU and CSR sides.
interface vx_lsu_csr_bridge_if #(
   parameter int NUM_THREADS = 4,
   parameter int ADDR_BITS   = 12,
   parameter int TAG_WIDTH   = 8
);

   logic                      req_valid;
   logic                      req_ready;
   logic                      req_rw;
   logic [ADDR_BITS-1:0]      req_addr;
   logic [NUM_THREADS-1:0]    req_mask;
   logic [NUM_THREADS*32-1:0] req_data;
   logic [TAG_WIDTH-1:0]      req_tag;

   logic                      rsp_valid;
   logic                      rsp_ready;
   logic [NUM_THREADS*32-1:0] rsp_data;
   logic [NUM_THREADS-1:0]    rsp_mask;
   logic [TAG_WIDTH-1:0]      rsp_tag;

   logic                      csr_grant;
   logic                      csr_read_enable;
   logic [ADDR_BITS-1:0]      csr_read_addr;
   logic [31:0]               csr_read_data;
   logic                      csr_write_enable;
   logic [ADDR_BITS-1:0]      csr_write_addr;
   logic [31:0]               csr_write_data;

   modport slave (
      input  req_valid, req_rw, req_addr, req_mask, req_data, req_tag,
      input  rsp_ready, csr_grant, csr_read_data,
      output req_ready, rsp_valid, rsp_data, rsp_mask, rsp_tag,
      output csr_read_enable, csr_read_addr,
      output csr_write_enable, csr_write_addr, csr_write_data
   );

   modport master (
      output req_valid, req_rw, req_addr, req_mask, req_data, req_tag,
      output rsp_ready, csr_grant, csr_read_data,
      input  req_ready, rsp_valid, rsp_data, rsp_mask, rsp_tag,
      input  csr_read_enable, csr_read_addr,
      input  csr_write_enable, csr_write_addr, csr_write_data
   );

endinterface

// File: rtl/vx_lsu_csr_bridge.sv
// Queues LSU CSR requests and issues them one at a time on the shared CSR port whenever
// the CSR unit grants it, returning one response per request in push order.
module vx_lsu_csr_bridge #(
   parameter int NUM_THREADS = 4,
   parameter int ADDR_BITS   = 12,
   parameter int TAG_WIDTH   = 8,
   parameter int FIFO_DEPTH  = 4
) (
   input logic                clk_i,
   input logic                reset_n_i,
   vx_lsu_csr_bridge_if.slave bus
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;

   typedef enum logic [1:0] {
      IDLE,
      RD_WAIT,
      RESP
   } state_e;

   typedef struct packed {
      logic                   rw;
      logic [ADDR_BITS-1:0]   addr;
      logic [NUM_THREADS-1:0] mask;
      logic [31:0]            wdata;
      logic [TAG_WIDTH-1:0]   tag;
   } entry_t;

   entry_t                    fifoMem_q [FIFO_DEPTH];
   entry_t                    pushEntry;
   entry_t                    headEntry;
   logic [PTR_W-1:0]          wrPtr_q;
   logic [PTR_W-1:0]          rdPtr_q;
   logic [CNT_W-1:0]          count_q;
   logic [CNT_W-1:0]          count_d;
   logic                      canAccept;
   logic                      push;
   logic                      pop;
   logic                      strobeActive;
   logic                      readStrobe;
   logic                      writeStrobe;

   state_e                    state_q;
   logic                      rspValid_q;
   logic [NUM_THREADS*32-1:0] rspData_q;
   logic [NUM_THREADS-1:0]    rspMask_q;
   logic [TAG_WIDTH-1:0]      rspTag_q;
   logic [NUM_THREADS-1:0]    pendMask_q;
   logic [TAG_WIDTH-1:0]      pendTag_q;

   // Acceptance looks only at the registered count, so a pop in the same cycle never frees a full slot.
   assign canAccept    = count_q < CNT_W'(FIFO_DEPTH);
   assign push         = bus.req_valid && canAccept;
   assign headEntry    = fifoMem_q[rdPtr_q];
   assign pop          = (state_q == IDLE) && (count_q != '0) && bus.csr_grant;
   assign strobeActive = pop && (headEntry.mask != '0);
   assign writeStrobe  = strobeActive && headEntry.rw;
   assign readStrobe   = strobeActive && !headEntry.rw;

   // A write carries a single 32-bit value: the data of the lowest active lane.
   always_comb begin
      pushEntry       = '0;
      pushEntry.rw    = bus.req_rw;
      pushEntry.addr  = bus.req_addr;
      pushEntry.mask  = bus.req_mask;
      pushEntry.tag   = bus.req_tag;
      for (int i = NUM_THREADS - 1; i >= 0; i--) begin
         if (bus.req_mask[i]) begin
            pushEntry.wdata = bus.req_data[i*32 +: 32];
         end
      end
   end

   always_comb begin
      count_d = count_q;
      if (push && !pop) begin
         count_d = count_q + CNT_W'(1);
      end else if (!push && pop) begin
         count_d = count_q - CNT_W'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (push) begin
         fifoMem_q[wrPtr_q] <= pushEntry;
      end
   end

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         wrPtr_q <= '0;
         rdPtr_q <= '0;
         count_q <= '0;
      end else begin
         count_q <= count_d;
         if (push) begin
            wrPtr_q <= wrPtr_q + PTR_W'(1);
         end
         if (pop) begin
            rdPtr_q <= rdPtr_q + PTR_W'(1);
         end
      end
   end

   // Reads take one extra cycle because the CSR unit returns data the cycle after the strobe.
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state_q    <= IDLE;
         rspValid_q <= 1'b0;
         rspData_q  <= '0;
         rspMask_q  <= '0;
         rspTag_q   <= '0;
         pendMask_q <= '0;
         pendTag_q  <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (pop) begin
                  if (headEntry.rw) begin
                     rspData_q  <= '0;
                     rspMask_q  <= headEntry.mask;
                     rspTag_q   <= headEntry.tag;
                     rspValid_q <= 1'b1;
                     state_q    <= RESP;
                  end else begin
                     pendMask_q <= headEntry.mask;
                     pendTag_q  <= headEntry.tag;
                     state_q    <= RD_WAIT;
                  end
               end
            end
            RD_WAIT: begin
               for (int i = 0; i < NUM_THREADS; i++) begin
                  rspData_q[i*32 +: 32] <= pendMask_q[i] ? bus.csr_read_data : 32'h0;
               end
               rspMask_q  <= pendMask_q;
               rspTag_q   <= pendTag_q;
               rspValid_q <= 1'b1;
               state_q    <= RESP;
            end
            RESP: begin
               if (bus.rsp_ready) begin
                  rspValid_q <= 1'b0;
                  state_q    <= IDLE;
               end
            end
            default: begin
               rspValid_q <= 1'b0;
               state_q    <= IDLE;
            end
         endcase
      end
   end

   assign bus.req_ready        = canAccept;
   assign bus.rsp_valid        = rspValid_q;
   assign bus.rsp_data         = rspData_q;
   assign bus.rsp_mask         = rspMask_q;
   assign bus.rsp_tag          = rspTag_q;
   assign bus.csr_read_enable  = readStrobe;
   assign bus.csr_read_addr    = readStrobe ? headEntry.addr : '0;
   assign bus.csr_write_enable = writeStrobe;
   assign bus.csr_write_addr   = writeStrobe ? headEntry.addr : '0;
   assign bus.csr_write_data   = writeStrobe ? headEntry.wdata : 32'h0;

endmodule
